// File: rtl/pwm_deadtime_ctrl_pkg.sv
// Shared state encoding, default counter width and effective-timing clamps
// for the buck gate-drive modulator.
package buck_ctrl_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        HS_ON,
        DEAD_HL,
        LS_ON,
        DEAD_LH
    } pwm_state_t;

    // A period shorter than two cycles cannot hold both a high and a low phase.
    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p < 32'd2) ? 32'd2 : p;
    endfunction

    function automatic logic [31:0] eff_duty(input logic [31:0] d, input logic [31:0] pe);
        return (d > pe) ? pe : d;
    endfunction

    function automatic logic [31:0] eff_dead(input logic [31:0] t);
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/pwm_deadtime_ctrl_if.sv
// Control, comparator and gate-drive bundle between the modulator and the
// host / power-stage model.
interface pwm_deadtime_ctrl_if #(
    parameter int CNT_W = buck_ctrl_pkg::DEF_CNT_W
);
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] dead;
    logic             ls_en;
    logic             hs;
    logic             ls;
    logic             period_start;
    logic             de_active;

    modport master (
        output en, period, duty, dead, ls_en,
        input  hs, ls, period_start, de_active
    );

    modport slave (
        input  en, period, duty, dead, ls_en,
        output hs, ls, period_start, de_active
    );
endinterface

// File: rtl/pwm_deadtime_ctrl_counter.sv
// Period counter with shadowed, clamped timing registers; exposes next-cycle
// values so the gate flops can be computed against the cnt they will coincide with.
module pwm_period_counter
    import buck_ctrl_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_DUTY   = 100,
    parameter int DEF_DEAD   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] dead,
    output logic             run_d,
    output logic [CNT_W-1:0] cnt_d,
    output logic [CNT_W-1:0] pe_d,
    output logic [CNT_W-1:0] de_d,
    output logic [CNT_W-1:0] te_d,
    output logic             period_start_q
);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pe_q;
    logic [CNT_W-1:0] de_q;
    logic [CNT_W-1:0] te_q;
    logic             period_start_d;
    logic             wrap;
    logic             load;
    logic [31:0]      pe_load;

    // Shadows only move at start-up or at the last cycle of a period.
    always_comb begin
        wrap    = run_q && (cnt_q == pe_q - CNT_W'(1));
        load    = en && (!run_q || wrap);
        pe_load = eff_period(32'(period));
        run_d   = en;
        pe_d    = pe_q;
        de_d    = de_q;
        te_d    = te_q;
        if (load) begin
            pe_d = CNT_W'(pe_load);
            de_d = CNT_W'(eff_duty(32'(duty), pe_load));
            te_d = CNT_W'(eff_dead(32'(dead)));
        end
        cnt_d = '0;
        if (en && run_q && !wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        period_start_d = en && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q          <= 1'b0;
            cnt_q          <= '0;
            pe_q           <= CNT_W'(DEF_PERIOD);
            de_q           <= CNT_W'(DEF_DUTY);
            te_q           <= CNT_W'(DEF_DEAD);
            period_start_q <= 1'b0;
        end else begin
            run_q          <= run_d;
            cnt_q          <= cnt_d;
            pe_q           <= pe_d;
            de_q           <= de_d;
            te_q           <= te_d;
            period_start_q <= period_start_d;
        end
    end

endmodule

// File: rtl/pwm_deadtime_ctrl.sv
// Complementary hs/ls gate generator with programmable dead time and
// per-period latched diode emulation.
module pwm_deadtime_ctrl
    import buck_ctrl_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_DUTY   = 100,
    parameter int DEF_DEAD   = 2
) (
    input logic               clk,
    input logic               rst,
    pwm_deadtime_ctrl_if.slave bus
);

    logic             run_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] pe_nxt;
    logic [CNT_W-1:0] de_nxt;
    logic [CNT_W-1:0] te_nxt;
    logic             period_start_q;

    pwm_period_counter #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_DUTY   (DEF_DUTY),
        .DEF_DEAD   (DEF_DEAD)
    ) u_counter (
        .clk            (clk),
        .rst            (rst),
        .en             (bus.en),
        .period         (bus.period),
        .duty           (bus.duty),
        .dead           (bus.dead),
        .run_d          (run_nxt),
        .cnt_d          (cnt_nxt),
        .pe_d           (pe_nxt),
        .de_d           (de_nxt),
        .te_d           (te_nxt),
        .period_start_q (period_start_q)
    );

    pwm_state_t     state_q, state_d;
    logic           hs_q, hs_d;
    logic           ls_q, ls_d;
    logic           de_active_q, de_active_d;
    logic           de_sample;
    logic [CNT_W:0] cnt_x;
    logic [CNT_W:0] ls_open;
    logic [CNT_W:0] ls_guard;

    // Phase is decoded from the upcoming cnt; the extra bit keeps De+Te and cnt+Te from wrapping.
    always_comb begin
        cnt_x    = {1'b0, cnt_nxt};
        ls_open  = {1'b0, de_nxt} + {1'b0, te_nxt};
        ls_guard = cnt_x + {1'b0, te_nxt};
        state_d  = IDLE;
        if (run_nxt) begin
            if (cnt_nxt < de_nxt) begin
                state_d = HS_ON;
            end else if (cnt_x < ls_open) begin
                state_d = DEAD_HL;
            end else if (ls_guard < {1'b0, pe_nxt}) begin
                state_d = LS_ON;
            end else begin
                state_d = DEAD_LH;
            end
        end
        de_sample   = (state_q == LS_ON) || (state_d == LS_ON);
        de_active_d = 1'b0;
        if (run_nxt && (cnt_nxt != '0)) begin
            de_active_d = de_active_q || (de_sample && !bus.ls_en);
        end
        hs_d = (state_d == HS_ON);
        ls_d = (state_d == LS_ON) && !de_active_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hs_q        <= 1'b0;
            ls_q        <= 1'b0;
            de_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hs_d;
            ls_q        <= ls_d;
            de_active_q <= de_active_d;
        end
    end

    assign bus.hs           = hs_q;
    assign bus.ls           = ls_q;
    assign bus.period_start = period_start_q;
    assign bus.de_active    = de_active_q;

endmodule

// File: doc/pwm_deadtime_ctrl.md
Name: pwm_deadtime_ctrl

Overview:
- Generates the complementary high-side/low-side gate signals (hs, ls) consumed directly by the buck power-stage model, replacing the fixed-duty PWM macro and the combinational ls gating.
- Provides programmable period, duty and dead time, with period-boundary shadow loading.
- Performs latched diode emulation from the inductor-current comparator output (ls_en).

Parameters:
- CNT_W, 16, width of the period counter and of all timing inputs.
- DEF_PERIOD, 200, period in clk cycles loaded into the shadow register at reset.
- DEF_DUTY, 100, hs on-time in cycles loaded at reset.
- DEF_DEAD, 2, dead time in cycles loaded at reset.

Ports:
- clk  in  1  system/emulator clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  modulator enable.
- period  in  CNT_W  requested period P in cycles.
- duty  in  CNT_W  requested hs on-time D in cycles.
- dead  in  CNT_W  requested dead time T in cycles.
- ls_en  in  1  synchronous comparator result; 1 = inductor current above the ls threshold.
- hs  out  1  high-side gate drive.
- ls  out  1  low-side gate drive.
- period_start  out  1  one-cycle pulse in the first cycle of each period.
- de_active  out  1  1 while diode emulation has latched ls off in the current period.

Behaviour:
- Reset (rst=0, async):
  - cnt=0, state=IDLE.
  - hs=ls=period_start=de_active=0.
  - Shadow registers load DEF_PERIOD/DEF_DUTY/DEF_DEAD.
- All outputs are registered. In any cycle, the output values correspond to the registered cnt of that cycle.
- Effective values, computed at shadow load:
  - Pe = max(P,2).
  - De = min(D,Pe).
  - Te = max(T,1).
- Shadow load: period/duty/dead are sampled only at IDLE->RUN and at wrap (cnt==Pe-1). Mid-period changes have no effect until the next period.
- Counter: cnt runs 0..Pe-1 and wraps to 0. period_start=1 in every cycle where cnt==0 while running.
- States:
  - IDLE -> HS_ON when en=1. The first running cycle has cnt=0.
  - HS_ON: hs=1 for cnt in [0, De-1]. Skipped entirely if De==0.
  - DEAD_HL: both outputs low for cnt in [De, De+Te-1].
  - LS_ON: ls=1 for cnt in [De+Te, Pe-Te-1], provided diode emulation has not latched.
  - DEAD_LH: both outputs low for cnt in [Pe-Te, Pe-1]. At wrap -> HS_ON.
  - If De+Te > Pe-Te-1, the LS_ON window is empty and ls stays 0 for that period.
  - If De==Pe, hs=1 for the whole period and ls never asserts.
- Diode emulation:
  - ls_en is sampled each cycle within the LS window.
  - If ls_en=0 is sampled in cycle k, then ls=0 and de_active=1 from cycle k+1.
  - The latch holds for the rest of the period; ls does not reassert even if ls_en returns to 1.
  - If ls_en=0 in the cycle before the window opens, ls never rises in that period.
  - de_active clears at wrap.
- en=0 while running: on the next edge hs=ls=0, cnt=0, state=IDLE, and de_active and period_start clear. Re-enabling restarts at cnt=0 with a fresh shadow load.
- Invariants:
  - hs & ls is never 1.
  - Every hs<->ls transition has at least Te cycles with both low.
  - Outputs are glitch-free (flop-driven).
- Reset mid-period: all outputs low immediately (async). Operation restarts from IDLE after deassertion.

Decomposition:
- Package buck_ctrl_pkg holds:
  - the state enum (IDLE, HS_ON, DEAD_HL, LS_ON, DEAD_LH);
  - the default CNT_W;
  - the effective-value clamp functions (eff_period, eff_duty, eff_dead).
- One sub-module, pwm_period_counter: shadow registers, clamping, cnt and wrap/period_start generation.
- The top level holds the FSM, the diode-emulation latch and the output flops.

Test Plan:
- P=10, D=5, T=1, ls_en=1, en=1 -> per period: hs=1 at cnt 0-4; ls=1 at cnt 6-8; both low at cnt 5 and 9; period_start pulse at cnt 0.
- Same settings, ls_en driven 0 at cnt 7 -> ls=0 from cnt 8 and de_active=1 until wrap. ls_en back to 1 at cnt 8 -> ls stays 0. The next period resumes normally.
- Change D 5->8 at cnt 3 -> the current period is unchanged (hs ends at cnt 4). Next period: hs at cnt 0-7 and empty LS window (8+1 > 8), so ls=0.
- D=10 (=P) -> hs constantly 1 and ls never 1. D=0, T=0 (Te=1) -> hs never 1 and ls at cnt 1-8.
- en dropped at cnt 6 while ls=1 -> next cycle hs=ls=0 and IDLE. Re-enable -> the first cycle has cnt=0 with hs=1.
- Async rst low at cnt 2 (hs=1) -> hs drops without a clock edge. After release with en=1: DEF timing is used, hs for 100 cycles, ls at cnt 102-197. A hs&ls assertion checker runs throughout all tests.
